// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM encoding for the multi-port register file.
package regfile_pkg;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_NUM_REG    = 16;
    localparam int DEF_INDEX_SIZE = $clog2(DEF_NUM_REG);
    localparam int DEF_NUM_READ   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Write/read/clear bus of the multi-port register file; the slave side is the register file.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int INDEX_SIZE = DEF_INDEX_SIZE,
    parameter int NUM_READ   = DEF_NUM_READ
);

    logic                           we0;
    logic [INDEX_SIZE-1:0]          waddr0;
    logic [WORD_SIZE-1:0]           wdata0;
    logic                           we1;
    logic [INDEX_SIZE-1:0]          waddr1;
    logic [WORD_SIZE-1:0]           wdata1;
    logic [NUM_READ*INDEX_SIZE-1:0] raddr;
    logic [NUM_READ*WORD_SIZE-1:0]  rdata;
    logic                           clr_req;
    logic                           clr_busy;
    logic                           clr_done;
    logic                           err_clr;
    logic                           collision_err;
    logic                           drop_err;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req, err_clr,
        input  rdata, clr_busy, clr_done, collision_err, drop_err
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req, err_clr,
        output rdata, clr_busy, clr_done, collision_err, drop_err
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: stored word, optional forwarding of this cycle's write, zero register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int NUM_REG    = DEF_NUM_REG,
    parameter int INDEX_SIZE = DEF_INDEX_SIZE,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic [WORD_SIZE-1:0]  mem [NUM_REG],
    input  logic [INDEX_SIZE-1:0] raddr,
    input  logic                  wen0,
    input  logic [INDEX_SIZE-1:0] waddr0,
    input  logic [WORD_SIZE-1:0]  wdata0,
    input  logic                  wen1,
    input  logic [INDEX_SIZE-1:0] waddr1,
    input  logic [WORD_SIZE-1:0]  wdata1,
    output logic [WORD_SIZE-1:0]  rdata
);

    // wen0/wen1 arrive already gated by the clear engine and zero register,
    // so forwarding is automatically off while a clear is sweeping.
    always_comb begin
        rdata = mem[raddr];
        if (BYPASS != 0) begin
            if (wen1 && (waddr1 == raddr)) begin
                rdata = wdata1;
            end else if (wen0 && (waddr0 == raddr)) begin
                rdata = wdata0;
            end
        end
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Dual-write, NUM_READ-read register file with collision priority, write bypass,
// optional zero register and a one-register-per-cycle bulk-clear engine.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int NUM_REG    = DEF_NUM_REG,
    parameter int INDEX_SIZE = DEF_INDEX_SIZE,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_multiport_if.slave bus
);

    logic [WORD_SIZE-1:0]  mem_reg  [NUM_REG];
    logic [WORD_SIZE-1:0]  mem_next [NUM_REG];
    clr_state_t            state_reg;
    logic [INDEX_SIZE-1:0] cnt_reg;
    logic                  clr_done_reg;
    logic                  collision_err_reg;
    logic                  drop_err_reg;

    logic busy;
    logic zero_hit0;
    logic zero_hit1;
    logic wen0;
    logic wen1;
    logic collision_evt;
    logic drop_evt;

    assign busy      = (state_reg == CLEAR);
    assign zero_hit0 = (ZERO_REG != 0) && (bus.waddr0 == '0);
    assign zero_hit1 = (ZERO_REG != 0) && (bus.waddr1 == '0);

    // Writes to a hardwired zero register vanish before arbitration, so they
    // can neither commit, forward nor count as a collision.
    assign wen0          = bus.we0 && !busy && !zero_hit0;
    assign wen1          = bus.we1 && !busy && !zero_hit1;
    assign collision_evt = wen0 && wen1 && (bus.waddr0 == bus.waddr1);
    assign drop_evt      = busy && (bus.we0 || bus.we1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : gen_reg
            assign mem_next[gi] =
                busy ? ((cnt_reg == INDEX_SIZE'(gi)) ? '0 : mem_reg[gi]) :
                (wen1 && (bus.waddr1 == INDEX_SIZE'(gi))) ? bus.wdata1 :
                (wen0 && (bus.waddr0 == INDEX_SIZE'(gi))) ? bus.wdata0 :
                mem_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            mem_reg <= mem_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            clr_done_reg      <= 1'b0;
            collision_err_reg <= 1'b0;
            drop_err_reg      <= 1'b0;
        end else begin
            clr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= '0;
                    end
                end
                CLEAR: begin
                    // The final sweep write happens on this same edge.
                    if (cnt_reg == INDEX_SIZE'(NUM_REG - 1)) begin
                        state_reg    <= IDLE;
                        clr_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + INDEX_SIZE'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A fresh error event outranks a simultaneous flag clear.
            if (collision_evt) begin
                collision_err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                collision_err_reg <= 1'b0;
            end

            if (drop_evt) begin
                drop_err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                drop_err_reg <= 1'b0;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : gen_rd
            regfile_read_port #(
                .WORD_SIZE (WORD_SIZE),
                .NUM_REG   (NUM_REG),
                .INDEX_SIZE(INDEX_SIZE),
                .BYPASS    (BYPASS),
                .ZERO_REG  (ZERO_REG)
            ) u_rd (
                .mem   (mem_reg),
                .raddr (bus.raddr[gi*INDEX_SIZE +: INDEX_SIZE]),
                .wen0  (wen0),
                .waddr0(bus.waddr0),
                .wdata0(bus.wdata0),
                .wen1  (wen1),
                .waddr1(bus.waddr1),
                .wdata1(bus.wdata1),
                .rdata (bus.rdata[gi*WORD_SIZE +: WORD_SIZE])
            );
        end
    endgenerate

    assign bus.clr_busy      = busy;
    assign bus.clr_done      = clr_done_reg;
    assign bus.collision_err = collision_err_reg;
    assign bus.drop_err      = drop_err_reg;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed checks of three register-file variants (bypass, no bypass, zero register) on shared stimulus.
module tb_regfile_multiport;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [3:0] waddr0 = '0, waddr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic [7:0] raddr = '0;
    logic       clr_req = 1'b0, err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.WORD_SIZE(8), .INDEX_SIZE(4), .NUM_READ(2)) if_a ();
    regfile_multiport_if #(.WORD_SIZE(8), .INDEX_SIZE(4), .NUM_READ(2)) if_b ();
    regfile_multiport_if #(.WORD_SIZE(8), .INDEX_SIZE(4), .NUM_READ(2)) if_c ();

    always_comb begin
        if_a.we0 = we0; if_a.waddr0 = waddr0; if_a.wdata0 = wdata0;
        if_a.we1 = we1; if_a.waddr1 = waddr1; if_a.wdata1 = wdata1;
        if_a.raddr = raddr; if_a.clr_req = clr_req; if_a.err_clr = err_clr;
        if_b.we0 = we0; if_b.waddr0 = waddr0; if_b.wdata0 = wdata0;
        if_b.we1 = we1; if_b.waddr1 = waddr1; if_b.wdata1 = wdata1;
        if_b.raddr = raddr; if_b.clr_req = clr_req; if_b.err_clr = err_clr;
        if_c.we0 = we0; if_c.waddr0 = waddr0; if_c.wdata0 = wdata0;
        if_c.we1 = we1; if_c.waddr1 = waddr1; if_c.wdata1 = wdata1;
        if_c.raddr = raddr; if_c.clr_req = clr_req; if_c.err_clr = err_clr;
    end

    regfile_multiport #(.BYPASS(1), .ZERO_REG(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    regfile_multiport #(.BYPASS(0), .ZERO_REG(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    regfile_multiport #(.BYPASS(1), .ZERO_REG(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    function automatic logic [7:0] pick(input logic [15:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [3:0] p0, input logic [3:0] p1);
        raddr = {p1, p0};
    endtask

    task automatic test_reset();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_a.clr_busy, if_a.clr_done, if_a.collision_err, if_a.drop_err,
             if_b.clr_busy, if_b.collision_err, if_c.clr_busy, if_c.drop_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got a=%b%b%b%b expected 0000", if_a.clr_busy,
                     if_a.clr_done, if_a.collision_err, if_a.drop_err);
        end
        for (int i = 0; i < 16; i++) begin
            set_raddr(4'(i), 4'(15 - i));
            #1;
            checks++;
            if (if_a.rdata !== 16'h0000 || if_b.rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read[%0d]: got a=%h b=%h expected 0000", i, if_a.rdata, if_b.rdata);
            end
        end
        rst_n = 1'b1;
        tick();
        $display("reset: registers and flags checked");
    endtask

    task automatic test_bypass();
        set_raddr(4'd2, 4'd0);
        we0 = 1'b1; waddr0 = 4'd2; wdata0 = 8'h10;
        #1;
        checks++;
        if (pick(if_a.rdata, 0) !== 8'h10) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected 10", pick(if_a.rdata, 0));
        end
        checks++;
        if (pick(if_b.rdata, 0) !== 8'h00) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h expected 00", pick(if_b.rdata, 0));
        end
        tick();
        we0 = 1'b0;
        #1;
        checks++;
        if (pick(if_a.rdata, 0) !== 8'h10 || pick(if_b.rdata, 0) !== 8'h10) begin
            errors++;
            $display("FAIL bypass_after_edge: got a=%h b=%h expected 10", pick(if_a.rdata, 0), pick(if_b.rdata, 0));
        end
        $display("bypass: reg2 <= 10 forwarded=%h stored=%h", pick(if_a.rdata, 0), pick(if_b.rdata, 0));
    endtask

    task automatic test_collision();
        set_raddr(4'd0, 4'd5);
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 8'hAA;
        we1 = 1'b1; waddr1 = 4'd5; wdata1 = 8'h55;
        #1;
        checks++;
        if (pick(if_a.rdata, 1) !== 8'h55 || pick(if_b.rdata, 1) !== 8'h00) begin
            errors++;
            $display("FAIL collision_bypass_prio: got a=%h b=%h expected 55/00", pick(if_a.rdata, 1), pick(if_b.rdata, 1));
        end
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        checks++;
        if (pick(if_b.rdata, 1) !== 8'h55 || pick(if_c.rdata, 1) !== 8'h55) begin
            errors++;
            $display("FAIL collision_winner: got b=%h c=%h expected 55", pick(if_b.rdata, 1), pick(if_c.rdata, 1));
        end
        checks++;
        if ({if_a.collision_err, if_b.collision_err, if_c.collision_err} !== 3'b111) begin
            errors++;
            $display("FAIL collision_flag: got %b expected 111", {if_a.collision_err, if_b.collision_err, if_c.collision_err});
        end
        // Set and clear in the same cycle: the set must win.
        we0 = 1'b1; we1 = 1'b1; waddr0 = 4'd6; waddr1 = 4'd6; err_clr = 1'b1;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        checks++;
        if (if_a.collision_err !== 1'b1) begin
            errors++;
            $display("FAIL collision_set_wins: got %b expected 1", if_a.collision_err);
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (if_a.collision_err !== 1'b0 || if_c.collision_err !== 1'b0) begin
            errors++;
            $display("FAIL collision_err_clr: got a=%b c=%b expected 0", if_a.collision_err, if_c.collision_err);
        end
        $display("collision: reg5 = 55, flag cleared");
    endtask

    task automatic test_clear_sweep();
        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1; waddr0 = 4'(i); wdata0 = 8'(i + 1);
            tick();
        end
        we0 = 1'b0;
        set_raddr(4'd15, 4'd0);
        #1;
        checks++;
        if (pick(if_a.rdata, 0) !== 8'h10 || pick(if_a.rdata, 1) !== 8'h01 || pick(if_c.rdata, 1) !== 8'h00) begin
            errors++;
            $display("FAIL preload: got a=%h c0=%h expected 10 01 / 00", if_a.rdata, pick(if_c.rdata, 1));
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            set_raddr(4'(c), (c == 0) ? 4'd0 : 4'(c - 1));
            if (c == 5) clr_req = 1'b1;
            if (c == 8) begin
                we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'hFF;
                we1 = 1'b1; waddr1 = 4'd8; wdata1 = 8'hEE;
            end
            if (c == 10) begin
                we0 = 1'b1; waddr0 = 4'd12; wdata0 = 8'h12;
                we1 = 1'b1; waddr1 = 4'd12; wdata1 = 8'h21;
            end
            #1;
            checks++;
            if (if_a.clr_busy !== 1'b1 || if_a.clr_done !== 1'b0 || if_c.clr_busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep_status[%0d]: got busy=%b done=%b expected 1 0", c, if_a.clr_busy, if_a.clr_done);
            end
            checks++;
            if (pick(if_a.rdata, 0) !== 8'(c + 1)) begin
                errors++;
                $display("FAIL sweep_unswept[%0d]: got %h expected %h", c, pick(if_a.rdata, 0), 8'(c + 1));
            end
            if (c > 0) begin
                checks++;
                if (pick(if_a.rdata, 1) !== 8'h00) begin
                    errors++;
                    $display("FAIL sweep_swept[%0d]: got %h expected 00", c, pick(if_a.rdata, 1));
                end
            end
            tick();
            clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
        end
        set_raddr(4'd3, 4'd12);
        #1;
        checks++;
        if (if_a.clr_busy !== 1'b0 || if_a.clr_done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_done: got busy=%b done=%b expected 0 1", if_a.clr_busy, if_a.clr_done);
        end
        checks++;
        if (if_a.rdata !== 16'h0000 || if_a.drop_err !== 1'b1 || if_a.collision_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_during_clear: got rdata=%h drop=%b coll=%b expected 0000 1 0", if_a.rdata, if_a.drop_err, if_a.collision_err);
        end
        // clr_req in the clr_done cycle starts another sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checks++;
        if (if_a.clr_busy !== 1'b1 || if_a.clr_done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_start: got busy=%b done=%b expected 1 0", if_a.clr_busy, if_a.clr_done);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (if_a.clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_len: got busy=%b expected 1", if_a.clr_busy);
        end
        tick();
        checks++;
        if (if_a.clr_done !== 1'b1 || if_a.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_done: got done=%b busy=%b expected 1 0", if_a.clr_done, if_a.clr_busy);
        end
        tick();
        checks++;
        if (if_a.clr_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b expected 0", if_a.clr_done);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (if_a.drop_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_err_clr: got %b expected 0", if_a.drop_err);
        end
        $display("clear_sweep: 16-cycle sweep, ignored re-request, dropped writes, back-to-back clear");
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        we0 = 1'b1; waddr0 = 4'd10; wdata0 = 8'h5A;
        tick();
        we0 = 1'b0;
        set_raddr(4'd10, 4'd10);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_a.clr_busy !== 1'b0 || pick(if_a.rdata, 0) !== 8'h00 || if_a.clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy=%b r10=%h done=%b expected 0 00 0", if_a.clr_busy, pick(if_a.rdata, 0), if_a.clr_done);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_a.clr_done !== 1'b0 || if_a.clr_busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort_no_done: got activity=1 expected 0");
        end
        $display("reset_mid_clear: sweep aborted");
    endtask

    task automatic test_zero_reg();
        set_raddr(4'd1, 4'd0);
        we0 = 1'b1; waddr0 = 4'd0; wdata0 = 8'h77;
        #1;
        checks++;
        if (pick(if_c.rdata, 1) !== 8'h00 || pick(if_a.rdata, 1) !== 8'h77) begin
            errors++;
            $display("FAIL zero_same_cycle: got c=%h a=%h expected 00 77", pick(if_c.rdata, 1), pick(if_a.rdata, 1));
        end
        tick();
        we0 = 1'b0;
        #1;
        checks++;
        if (pick(if_c.rdata, 1) !== 8'h00 || pick(if_a.rdata, 1) !== 8'h77) begin
            errors++;
            $display("FAIL zero_after_edge: got c=%h a=%h expected 00 77", pick(if_c.rdata, 1), pick(if_a.rdata, 1));
        end
        we0 = 1'b1; we1 = 1'b1; waddr0 = 4'd0; waddr1 = 4'd0; wdata1 = 8'h66;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        checks++;
        if (if_c.collision_err !== 1'b0 || if_c.drop_err !== 1'b0 || if_a.collision_err !== 1'b1) begin
            errors++;
            $display("FAIL zero_no_flags: got c_coll=%b c_drop=%b a_coll=%b expected 0 0 1", if_c.collision_err, if_c.drop_err, if_a.collision_err);
        end
        checks++;
        if (pick(if_c.rdata, 1) !== 8'h00 || pick(if_a.rdata, 1) !== 8'h66) begin
            errors++;
            $display("FAIL zero_dual_write: got c=%h a=%h expected 00 66", pick(if_c.rdata, 1), pick(if_a.rdata, 1));
        end
        $display("zero_reg: reg0 writes discarded on zero-register variant");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_clear_sweep();
        test_reset_mid_clear();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised multi-port register file, the next generation of the 16x8 single-write, dual-read file. It adds asynchronous reset, configurable read-port count, a second write port with defined collision priority, optional write-to-read bypass, an optional hardwired zero register, and a sequenced bulk-clear engine with status flags. It sits between the accumulator/immediate path and the ALU, ACC and program-counter inputs.

Parameters:
WORD_SIZE, 8, bits per register
NUM_REG, 16, number of registers (power of two, >= 2)
INDEX_SIZE, 4, address width, equal to log2(NUM_REG)
NUM_READ, 2, number of read ports (1..8)
BYPASS, 1, 1 = a same-cycle write is forwarded to reads; 0 = reads return stored value only
ZERO_REG, 0, 1 = register 0 is hardwired to zero

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
we0  in  1  write enable, port 0
waddr0  in  INDEX_SIZE  write address, port 0
wdata0  in  WORD_SIZE  write data, port 0
we1  in  1  write enable, port 1 (priority port)
waddr1  in  INDEX_SIZE  write address, port 1
wdata1  in  WORD_SIZE  write data, port 1
raddr  in  NUM_READ*INDEX_SIZE  packed read addresses; port k uses bits [k*INDEX_SIZE +: INDEX_SIZE]
rdata  out  NUM_READ*WORD_SIZE  packed read data; port k uses bits [k*WORD_SIZE +: WORD_SIZE]
clr_req  in  1  start a bulk clear
clr_busy  out  1  bulk clear in progress
clr_done  out  1  one-cycle pulse when a clear completes
err_clr  in  1  clears the sticky error flags
collision_err  out  1  sticky: both write ports targeted the same address
drop_err  out  1  sticky: a write was dropped during a clear

Behaviour:
- Clock and reset: clk only; rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): all registers 0; FSM to IDLE; clear counter 0; clr_busy, clr_done, collision_err and drop_err all 0.
- Write path: writes commit on the rising edge of clk.
  - we0 and we1 to different addresses: both commit in the same cycle.
  - Same address: wdata1 wins and collision_err sets on that edge.
- Read path: combinational, zero latency.
  - rdata[k] = reg[raddr[k]].
  - BYPASS=1: if a write to raddr[k] is pending this cycle, rdata[k] returns that write data instead. Port 1 data takes precedence over port 0.
  - Bypass is suppressed while clr_busy=1, because user writes are dropped.
- ZERO_REG=1: writes to address 0 are silently discarded, with no error and no collision flag. Reads of address 0 always return 0, including via bypass.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1. Counter loads 0 and clr_busy=1 from the next cycle.
  - In CLEAR: each cycle writes 0 to reg[counter], then increments. Exactly NUM_REG cycles.
  - At counter = NUM_REG-1, the final clear write occurs. On the following edge the FSM returns to IDLE, clr_busy=0 and clr_done=1 for one cycle.
  - clr_req while busy is ignored. clr_req asserted in the cycle clr_done is high starts a new clear.
- During CLEAR:
  - Any we0/we1 assertion is dropped and sets drop_err. A collision during CLEAR does not set collision_err.
  - Reads return stored contents: registers not yet swept still show their old values.
- Sticky flags:
  - err_clr=1 clears both flags on the next edge.
  - If a new error event and err_clr occur in the same cycle, the set wins.
- Reset during CLEAR: the clear aborts immediately and all registers are zeroed asynchronously. clr_done does not pulse.
- Address width: INDEX_SIZE exactly covers NUM_REG, so no out-of-range handling is required.

Decomposition:
- Shared package regfile_pkg: default WORD_SIZE, NUM_REG, INDEX_SIZE, NUM_READ constants; FSM state encoding (IDLE=0, CLEAR=1).
- Sub-module regfile_read_port: one read mux with bypass and zero-register logic, instantiated NUM_READ times via generate.
- Storage array, write arbitration and clear FSM stay in the top module.

Test Plan:
1. Reset then read: assert rst_n=0 mid-cycle, read all 16 registers -> all rdata = 0, all flags 0.
2. Bypass: write reg2 = 16 (8'h10) via we0 while raddr port0 = 2, BYPASS=1 -> rdata port0 = 8'h10 in the same cycle and after the edge. With BYPASS=0 -> old value (0) until the edge, then 8'h10.
3. Collision: we0 and we1 both to reg5 with wdata0 = 8'hAA, wdata1 = 8'h55 -> reg5 = 8'h55 and collision_err = 1 after the edge. err_clr pulse -> collision_err = 0.
4. Clear sweep: preload reg0..reg15 = 8'h01..8'h10, pulse clr_req -> clr_busy high for 16 cycles, reg[i] reads 0 from cycle i+1, clr_done pulses once, all registers 0.
5. Write during clear: during CLEAR, we0 to reg3 = 8'hFF -> reg3 stays 0 after the clear, drop_err = 1.
6. Zero register: ZERO_REG=1, write reg0 = 8'h77, read port1 at reg0 -> rdata = 0 in the same cycle and after the edge, no error flags. Separately, rst_n low mid-clear -> clr_busy = 0 immediately and no clr_done pulse.
